seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed 4-digit 7-segment driver. It consumes two 15-bit BCD words from the binary-to-BCD stage:
//   bcd_hi (e.g. minutes) and bcd_lo (e.g. seconds). It scans the digits at a fixed refresh rate and drives
//   active-low anodes, segments and decimal point.
//   It sits between the BCD conversion stage and the board pins in the stopwatch/timer top level.
// PARAMETERS
//   CLK_HZ      100_000_000  input clock frequency
//   REFRESH_HZ  1000         digit-advance rate (per-digit dwell = 1/REFRESH_HZ)
//   DIV = CLK_HZ/REFRESH_HZ (localparam, must be >= 2). Prescaler width = $clog2(DIV).
// PORTS
//   clk      in   1   system clock, single clock domain
//   rst_n    in   1   synchronous reset, active-low
//   bcd_hi   in   15  BCD word, tens=[14:11], ones=[10:7], [6:0] ignored
//   bcd_lo   in   15  same format, lower digit pair
//   dp_mask  in   4   per-digit decimal point, active-high, bit i = digit i
//   blank    in   1   1 = all anodes off; scanning continues internally
//   an       out  4   anodes, active-low, one-hot-low when lit
//   seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp       out  1   decimal point, active-low
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): prescaler=0, digit idx=0, snapshot regs=0, an=4'hF, seg=7'h7F, dp=1.
//   Prescaler counts 0..DIV-1 and wraps. tick = (prescaler==DIV-1).
//   On tick: idx <= idx+1 (mod 4).
//   Digit map: idx0=lo.ones, idx1=lo.tens, idx2=hi.ones, idx3=hi.tens.
//   Frame-coherent snapshot: bcd_hi/bcd_lo/dp_mask are sampled into shadow regs on the tick where idx wraps 3->0.
//     The first snapshot occurs 4*DIV cycles after reset release. A mid-frame input change never tears a frame.
//   Outputs are registered: an/seg/dp reflect the new idx on the clock after the tick (1-cycle latency).
//   an = ~(4'b1 << idx) unless blank=1, in which case an=4'hF.
//   seg: nibble 0-9 -> standard glyph; nibble >9 -> dash (7'h3F, g only).
//   dp = ~dp_mask_shadow[idx].
//   blank takes effect on the next clock, unregistered w.r.t. the snapshot. Deassertion resumes the current idx.
//   Reset mid-scan: all state returns to reset values on that edge; no partial digit is held.
//   Simultaneous tick and snapshot is the normal wrap case: the new idx=0 digit shows the new snapshot.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digit3 blanked (seg=7'h7F, its anode still enabled) if its nibble==0.
//     digit2 is blanked if digit3 is blanked and its nibble==0. digit1 is blanked likewise if digit2 is blanked.
//     digit0 is never blanked. dp is unaffected by blanking.
//   Not defined: all four digits are always shown, including leading zeros.
// STRUCTURE
//   Package seg7_pkg: SEG_GLYPH[0:9] active-low constants, SEG_OFF=7'h7F, SEG_DASH=7'h3F, DIGITS=4.
//   Sub-module seg7_decode: combinational 4-bit nibble -> 7-bit active-low glyph, dash for >9.
//   Top: prescaler, idx counter, snapshot regs, LZB logic, output regs.
// TESTING (sim with CLK_HZ=1000, REFRESH_HZ=250 -> DIV=4)
//   Hold rst_n=0 5 clks -> an=4'hF, seg=7'h7F, dp=1 throughout. Release -> first anode change 5 clks later.
//   bcd_hi=15'h0900 (12), bcd_lo=15'h1A00 (34), after first wrap:
//     idx0..3 -> an E,D,B,7 with seg 19,30,24,79. Each dwell is exactly 4 clks.
//   Change bcd_lo mid-frame (idx=1) to 15'h2C80 (59) -> digits 0/1 still show 4/3 until the next wrap, then 9/5.
//   dp_mask=4'b0100 -> dp=0 only while an=4'hB. blank=1 for 10 clks -> an=4'hF, and idx continues advancing.
//   Nibble 4'hC in bcd_hi tens -> seg=7'h3F on digit3.
//   LEADING_ZERO_BLANK_EN with hi=00, lo=05 -> digits 3,2,1 seg=7'h7F, digit0 seg=7'h12.
//     hi=00, lo=00 -> only digit0 shows 7'h40.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}. All patterns are active-low.
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10   // 9
    };

    typedef logic [1:0] digit_idx_t;

    // One-hot-low anode pattern for a digit index.
    function automatic logic [3:0] anode_onehot_low(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment glyph.
// Non-decimal nibbles (A-F) show a dash so bad BCD is visible on the display.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = SEG_GLYPH[0];
            4'd1: seg = SEG_GLYPH[1];
            4'd2: seg = SEG_GLYPH[2];
            4'd3: seg = SEG_GLYPH[3];
            4'd4: seg = SEG_GLYPH[4];
            4'd5: seg = SEG_GLYPH[5];
            4'd6: seg = SEG_GLYPH[6];
            4'd7: seg = SEG_GLYPH[7];
            4'd8: seg = SEG_GLYPH[8];
            4'd9: seg = SEG_GLYPH[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-coherent input snapshot.
// Optional leading-zero blanking of digits 3..1 when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] bcd_hi,
    input  logic [14:0] bcd_lo,
    input  logic [3:0]  dp_mask,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // DIV must be >= 2; the prescaler then wraps at DIV-1.
    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    digit_idx_t    idx;
    logic          tick;
    logic          wrap;

    // Shadow copies of the BCD digit pairs; bits [6:0] of each word carry no digits.
    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic [3:0] dp_q;

    logic unused_low_bits;
    assign unused_low_bits = ^{bcd_hi[6:0], bcd_lo[6:0]};

    assign tick = (prescaler == PS_MAX);
    assign wrap = tick && (idx == digit_idx_t'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dp_q      <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Sampling only at the 3->0 wrap keeps every frame built from one input set.
            if (wrap) begin
                hi_q <= bcd_hi[14:7];
                lo_q <= bcd_lo[14:7];
                dp_q <= dp_mask;
            end
        end
    end

    logic [3:0] nib [DIGITS];
    assign nib[0] = lo_q[3:0];
    assign nib[1] = lo_q[7:4];
    assign nib[2] = hi_q[3:0];
    assign nib[3] = hi_q[7:4];

    logic [3:0] cur_nib;
    logic [6:0] cur_glyph;
    assign cur_nib = nib[idx];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_glyph)
    );

    logic [3:0] lz_mask;
    always_comb begin
        lz_mask = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        // Blanking ripples down from the most significant digit; digit 0 always shows.
        lz_mask[3] = (nib[3] == 4'd0);
        lz_mask[2] = lz_mask[3] && (nib[2] == 4'd0);
        lz_mask[1] = lz_mask[2] && (nib[1] == 4'd0);
`endif
    end

    logic [6:0] seg_next;
    assign seg_next = lz_mask[idx] ? SEG_OFF : cur_glyph;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? 4'hF : anode_onehot_low(idx);
            seg <= seg_next;
            dp  <= ~dp_q[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=4 (CLK_HZ=1000, REFRESH_HZ=250).
// Build with LEADING_ZERO_BLANK_EN defined to also exercise leading-zero blanking.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] bcd_hi = '0;
    logic [14:0] bcd_lo = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (250)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bcd_hi  (bcd_hi),
        .bcd_lo  (bcd_lo),
        .dp_mask (dp_mask),
        .blank   (blank),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } dwell_t;

    dwell_t tbl [8];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] PRE_HI = 7'h7F;
`else
    localparam logic [6:0] PRE_HI = 7'h40;
`endif

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all(input string name, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
        n_vec++;
        if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            n_err++;
            $display("FAIL %s cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                     name, cyc, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    task automatic check_an(input string name, input logic [3:0] e_an);
        n_vec++;
        if (an !== e_an) begin
            n_err++;
            $display("FAIL %s cyc=%0d got an=%h want an=%h", name, cyc, an, e_an);
        end
    endtask

    task automatic check_seg(input string name, input logic [6:0] e_seg);
        n_vec++;
        if (seg !== e_seg) begin
            n_err++;
            $display("FAIL %s cyc=%0d got seg=%h want seg=%h", name, cyc, seg, e_seg);
        end
    endtask

    // Anode expected after edge c (counted from reset release): shows idx of edge c-1.
    function automatic logic [3:0] exp_an(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (((c - 1) / 4) % 4));
    endfunction

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        logic [6:0] old_f [4];
        logic [6:0] new_f [4];
        old_f = '{7'h19, 7'h30, 7'h24, 7'h79};
        new_f = '{7'h10, 7'h12, 7'h24, 7'h79};

        // Before the first snapshot shadows are zero; from the first wrap on, 12/34 with dp on digit 2.
        tbl[0] = '{4'hE, 7'h40, 1'b1};
        tbl[1] = '{4'hD, PRE_HI, 1'b1};
        tbl[2] = '{4'hB, PRE_HI, 1'b1};
        tbl[3] = '{4'h7, PRE_HI, 1'b1};
        tbl[4] = '{4'hE, 7'h19, 1'b1};
        tbl[5] = '{4'hD, 7'h30, 1'b1};
        tbl[6] = '{4'hB, 7'h24, 1'b0};
        tbl[7] = '{4'h7, 7'h79, 1'b1};

        // Reset held for 5 clocks.
        bcd_hi  = 15'h0900;
        bcd_lo  = 15'h1A00;
        dp_mask = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("reset_hold", 4'hF, 7'h7F, 1'b1);
        end
        rst_n = 1'b1;
        cyc   = 0;

        // Two full frames, every cycle of every dwell checked.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                check_all("frame", tbl[i].an, tbl[i].seg, tbl[i].dp);
            end
        end

        // Mid-frame change of bcd_lo while idx=1 must not tear the current frame.
        run_to(37);
        bcd_lo = 15'h2C80;
        for (int c = 38; c <= 56; c++) begin
            exp_q.push_back((c <= 48) ? old_f[((c - 1) / 4) % 4] : new_f[((c - 1) / 4) % 4]);
        end
        while (exp_q.size() > 0) begin
            step();
            check_seg("no_tear", exp_q.pop_front());
            check_an("no_tear_an", exp_an(cyc));
        end

        // Tens nibble 0xC on the high pair shows a dash on digit 3.
        bcd_hi = 15'h6000;
        run_to(73);
        check_all("hi_ones_zero", 4'hB, 7'h40, 1'b0);
        run_to(77);
        check_all("dash_digit3", 4'h7, 7'h3F, 1'b1);

        // Blank for 10 clocks; scanning keeps going underneath.
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_an("blank", 4'hF);
        end
        blank = 1'b0;
        step();
        check_an("unblank_resume", 4'hD);
        check_an("unblank_model", exp_an(cyc));

        // Reset mid-scan clears outputs, prescaler, idx and snapshots.
        run_to(90);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset_mid", 4'hF, 7'h7F, 1'b1);
        end
        rst_n = 1'b1;
        cyc   = 0;
        step();
        check_all("post_reset_d0", 4'hE, 7'h40, 1'b1);
        run_to(4);
        check_an("post_reset_dwell", 4'hE);
        run_to(5);
        check_all("post_reset_d1", 4'hD, PRE_HI, 1'b1);

`ifdef LEADING_ZERO_BLANK_EN
        bcd_hi  = 15'h0000;
        bcd_lo  = 15'h0280;
        dp_mask = 4'b0000;
        run_to(17);
        check_all("lzb_05_d0", 4'hE, 7'h12, 1'b1);
        run_to(21);
        check_all("lzb_05_d1", 4'hD, 7'h7F, 1'b1);
        run_to(25);
        check_all("lzb_05_d2", 4'hB, 7'h7F, 1'b1);
        run_to(29);
        check_all("lzb_05_d3", 4'h7, 7'h7F, 1'b1);
        bcd_lo = 15'h0000;
        run_to(33);
        check_all("lzb_00_d0", 4'hE, 7'h40, 1'b1);
        run_to(37);
        check_all("lzb_00_d1", 4'hD, 7'h7F, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
